// File: rtl/rr_select8x8_if.sv
// rtl/rr_select8x8_if.sv - channel inputs, grant readies and registered output stream of rr_select8x8
interface rr_select8x8_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] I0, I1, I2, I3, I4, I5, I6, I7;
  logic [7:0]       V;
  logic [7:0]       L;
  logic [7:0]       R;
  logic [WIDTH-1:0] O;
  logic             O_valid;
  logic             O_last;
  logic             O_ready;
  logic [2:0]       S;

  modport master (
    output I0, I1, I2, I3, I4, I5, I6, I7, V, L, O_ready,
    input  R, O, O_valid, O_last, S
  );

  modport slave (
    input  I0, I1, I2, I3, I4, I5, I6, I7, V, L, O_ready,
    output R, O, O_valid, O_last, S
  );
endinterface

// File: rtl/rr_select8x8.sv
// rtl/rr_select8x8.sv - 8-channel round-robin arbiter with packet lock and registered output stage
module rr_select8x8 #(
  parameter int WIDTH = 8
) (
  input  logic            CLK,
  input  logic            ASYNCRESET,
  rr_select8x8_if.slave   bus
);
  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       owner_q, owner_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             last_q, last_d;
  logic [2:0]       s_q, s_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] din [8];
  logic [7:0]       eligible;
  logic [2:0]       g, idx;
  logic             found, load_en, xfer;

  assign din[0] = bus.I0;
  assign din[1] = bus.I1;
  assign din[2] = bus.I2;
  assign din[3] = bus.I3;
  assign din[4] = bus.I4;
  assign din[5] = bus.I5;
  assign din[6] = bus.I6;
  assign din[7] = bus.I7;

  assign load_en = !valid_q || bus.O_ready;

  // Rotating priority search starting at ptr; a locked packet masks every other channel.
  always_comb begin
    eligible = (state_q == LOCK) ? (bus.V & (8'b1 << owner_q)) : bus.V;
    found    = 1'b0;
    g        = ptr_q;
    idx      = ptr_q;
    for (int k = 0; k < 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
  end

  assign xfer  = load_en && found && !ASYNCRESET;
  assign bus.R = xfer ? (8'b1 << g) : 8'b0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    o_d     = o_q;
    last_d  = last_q;
    s_d     = s_q;
    valid_d = valid_q;
    if (xfer) begin
      o_d     = din[g];
      last_d  = bus.L[g];
      s_d     = g;
      valid_d = 1'b1;
      // ptr only moves at packet end, so fairness is counted in packets, not beats.
      if (bus.L[g]) begin
        state_d = IDLE;
        ptr_d   = g + 3'd1;
      end else begin
        state_d = LOCK;
        owner_d = g;
      end
    end else if (load_en) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      owner_q <= 3'd0;
      o_q     <= '0;
      last_q  <= 1'b0;
      s_q     <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      o_q     <= o_d;
      last_q  <= last_d;
      s_q     <= s_d;
      valid_q <= valid_d;
    end
  end

  assign bus.O       = o_q;
  assign bus.O_last  = last_q;
  assign bus.S       = s_q;
  assign bus.O_valid = valid_q;
endmodule

// File: tb/tb_rr_select8x8.sv
// tb/tb_rr_select8x8.sv - self-checking bench for rr_select8x8 against a per-packet round-robin model
module tb_rr_select8x8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_select8x8_if #(.WIDTH(8)) bus ();
  rr_select8x8 #(.WIDTH(8)) dut (.CLK(clk), .ASYNCRESET(rst), .bus(bus));

  logic [7:0] din [8];
  assign bus.I0 = din[0];
  assign bus.I1 = din[1];
  assign bus.I2 = din[2];
  assign bus.I3 = din[3];
  assign bus.I4 = din[4];
  assign bus.I5 = din[5];
  assign bus.I6 = din[6];
  assign bus.I7 = din[7];

  int errors = 0;
  int checks = 0;

  // Reference: packet-level state, next channel to favour, and the beat held downstream.
  int       m_ptr, m_owner;
  bit       m_lock, m_valid, m_last;
  int       m_s;
  bit [7:0] m_o;
  logic [7:0] r_seen, r_exp;

  function automatic int exp_grant(logic [7:0] v);
    for (int k = 0; k < 8; k++) begin
      int c;
      c = (m_ptr + k) % 8;
      if ((!m_lock || c == m_owner) && v[c] === 1'b1) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_lock = 0; m_valid = 0; m_last = 0; m_s = 0; m_o = 8'h00;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 8; i++) din[i] = 8'h10 + 8'(i);
  endtask

  task automatic tick(input logic [7:0] v, input logic [7:0] l, input logic ordy);
    int g;
    bit ld;
    bus.V = v; bus.L = l; bus.O_ready = ordy;
    #1;
    g  = exp_grant(v);
    ld = !m_valid || ordy;
    r_exp  = (ld && g >= 0) ? (8'h01 << g) : 8'h00;
    r_seen = bus.R;
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_o = din[g]; m_last = l[g]; m_s = g; m_valid = 1;
        if (l[g]) begin m_lock = 0; m_ptr = (g + 1) % 8; end
        else begin m_lock = 1; m_owner = g; end
      end else begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    bus.V = 8'h00; bus.L = 8'h00; bus.O_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_ramp();
    do_reset();
    tick(8'hFF, 8'h00, 1'b1);
    bus.V = 8'hFF; bus.O_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({bus.O, bus.S, bus.O_valid, bus.O_last} !== 13'h0) begin
      errors++; $display("FAIL reset_outputs O=%h S=%0d valid=%b last=%b expected all zero", bus.O, bus.S, bus.O_valid, bus.O_last);
    end
    checks++;
    if (bus.R !== 8'h00) begin errors++; $display("FAIL reset_ready R=%b expected 00000000", bus.R); end
    @(posedge clk); #1 rst = 1'b0;
    tick(8'hFF, 8'hFF, 1'b1);
    checks++;
    if (bus.S !== 3'd0 || bus.O !== 8'h10 || bus.O_valid !== 1'b1) begin
      errors++; $display("FAIL reset_first_grant S=%0d O=%h valid=%b expected S=0 O=10 valid=1", bus.S, bus.O, bus.O_valid);
    end
  endtask

  task automatic test_round_robin();
    set_ramp();
    do_reset();
    for (int k = 0; k < 9; k++) begin
      tick(8'hFF, 8'hFF, 1'b1);
      checks++;
      if (bus.S !== 3'(k % 8) || bus.O !== 8'h10 + 8'(k % 8) || bus.O_valid !== 1'b1 || bus.O_last !== 1'b1) begin
        errors++; $display("FAIL round_robin beat%0d S=%0d O=%h valid=%b expected S=%0d O=%h valid=1", k, bus.S, bus.O, bus.O_valid, k % 8, 8'h10 + k % 8);
      end
    end
  endtask

  task automatic test_back_pressure();
    set_ramp();
    do_reset();
    tick(8'hFF, 8'hFF, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick(8'hFF, 8'hFF, 1'b0);
      checks++;
      if (r_seen !== 8'h00 || bus.S !== 3'd0 || bus.O !== 8'h10 || bus.O_valid !== 1'b1) begin
        errors++; $display("FAIL back_pressure_hold%0d R=%b S=%0d O=%h expected R=0 S=0 O=10", k, r_seen, bus.S, bus.O);
      end
    end
    tick(8'hFF, 8'hFF, 1'b1);
    checks++;
    if (r_seen !== 8'h02 || bus.S !== 3'd1 || bus.O !== 8'h11 || bus.O_valid !== 1'b1) begin
      errors++; $display("FAIL back_pressure_release R=%b S=%0d O=%h expected R=00000010 S=1 O=11", r_seen, bus.S, bus.O);
    end
  endtask

  task automatic test_packet_lock();
    logic [7:0] lseq [4];
    int         sexp [4];
    lseq = '{8'h20, 8'h20, 8'h24, 8'h24};
    sexp = '{2, 2, 2, 5};
    set_ramp();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick(8'h24, lseq[k], 1'b1);
      checks++;
      if (bus.S !== 3'(sexp[k]) || bus.O_last !== (k >= 2) || r_seen !== (8'h01 << sexp[k])) begin
        errors++; $display("FAIL packet_lock beat%0d S=%0d last=%b R=%b expected S=%0d", k, bus.S, bus.O_last, r_seen, sexp[k]);
      end
    end
  endtask

  task automatic test_wrap_skip();
    logic [7:0] vseq [4];
    int         sexp [4];
    vseq = '{8'h40, 8'h81, 8'h81, 8'h01};
    sexp = '{6, 7, 0, 0};
    set_ramp();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick(vseq[k], 8'hFF, 1'b1);
      checks++;
      if (bus.S !== 3'(sexp[k]) || bus.O !== 8'h10 + 8'(sexp[k])) begin
        errors++; $display("FAIL wrap_skip step%0d S=%0d O=%h expected S=%0d", k, bus.S, bus.O, sexp[k]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    set_ramp();
    do_reset();
    tick(8'h08, 8'h00, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (bus.O_valid !== 1'b0 || bus.R !== 8'h00) begin
      errors++; $display("FAIL mid_packet_reset valid=%b R=%b expected valid=0 R=0", bus.O_valid, bus.R);
    end
    @(posedge clk); #1 rst = 1'b0;
    tick(8'h88, 8'h00, 1'b1);
    checks++;
    if (bus.S !== 3'd3 || bus.O !== 8'h13) begin
      errors++; $display("FAIL mid_packet_regrant S=%0d O=%h expected S=3 O=13", bus.S, bus.O);
    end
  endtask

  task automatic test_random();
    logic [7:0] v, l;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 8; i++) din[i] = 8'($urandom);
      v = 8'($urandom) & 8'($urandom | ($urandom_range(0, 1) ? 32'hFF : 32'h0));
      l = 8'($urandom);
      tick(v, l, ($urandom_range(0, 3) != 0));
      checks++;
      if (r_seen !== r_exp) begin
        errors++; $display("FAIL random_ready cycle%0d R=%b expected %b", n, r_seen, r_exp);
      end
      checks++;
      if (bus.O_valid !== m_valid || (m_valid && (bus.O !== m_o || bus.S !== 3'(m_s) || bus.O_last !== m_last))) begin
        errors++; $display("FAIL random_output cycle%0d valid=%b O=%h S=%0d last=%b expected valid=%b O=%h S=%0d last=%b",
                           n, bus.O_valid, bus.O, bus.S, bus.O_last, m_valid, m_o, m_s, m_last);
      end
    end
  endtask

  initial begin
    bus.V = 8'h00; bus.L = 8'h00; bus.O_ready = 1'b0;
    for (int i = 0; i < 8; i++) din[i] = 8'h00;
    model_reset();
    #2;
    test_reset();
    test_round_robin();
    test_back_pressure();
    test_packet_lock();
    test_wrap_skip();
    test_reset_mid_packet();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
